// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Constants shared by the fetch stage, CP0 and the ExcCode pipeline:
//   reset PC, exception entry address, legal instruction-memory window
//   and the AdEL exception code. Also holds the next-PC source encoding
//   and the fetch-address check helper.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] HANDLER_DEF  = 32'h0000_4180;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP_DEF   = 32'h0000_6FFC;

    localparam logic [4:0]  EXC_ADEL     = 5'd4;

    typedef enum logic [2:0] {
        NPC_EXC  = 3'd0,
        NPC_ERET = 3'd1,
        NPC_HOLD = 3'd2,
        NPC_BR   = 3'd3,
        NPC_SEQ  = 3'd4
    } npc_sel_e;

    // Unsigned 32-bit compares; a PC that wrapped past 0xFFFFFFFC lands
    // below the base and is flagged here.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] top);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// fetch_unit_pc_reg
//   32-bit register with asynchronous active-high reset and load enable.
//   Ports:
//     clk     - clock, rising edge
//     rst     - asynchronous reset, active-high, loads RESET_VAL
//     i_load  - load i_d on the next rising edge
//     i_d     - next value
//     o_q     - register contents
module fetch_unit_pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the PC, picks the next PC from the
//   exception entry, eret return, stall hold, branch redirect or
//   sequential sources, drives the instruction-memory address and flags
//   AdEL for misaligned or out-of-window fetch addresses.
//   Ports:
//     clk, reset            - clock and asynchronous active-high reset
//     stall                 - hold the F stage (ignored by exc_req/eret)
//     br_taken, br_target   - redirect from D
//     exc_req               - exception/interrupt entry to HANDLER
//     eret, epc             - return from exception to epc
//     im_addr, im_instr     - combinational instruction memory interface
//     F_PC, F_Instr         - PC and instruction currently in F
//     F_exc, F_ExcCode      - fetch address exception and its code
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] HANDLER  = HANDLER_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter logic [31:0] IM_TOP   = IM_TOP_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] F_PC,
    output logic [31:0] F_Instr,
    output logic        F_exc,
    output logic [4:0]  F_ExcCode
);

    npc_sel_e    w_sel;
    logic [31:0] w_pc;
    logic [31:0] w_next_pc;
    logic        w_load;
    logic        w_bad;

    // exc_req beats eret, and both beat stall; a branch seen during a stall
    // is dropped because D re-presents it once the stall clears.
    always_comb begin
        w_sel = NPC_SEQ;
        if (exc_req) begin
            w_sel = NPC_EXC;
        end else if (eret) begin
            w_sel = NPC_ERET;
        end else if (stall) begin
            w_sel = NPC_HOLD;
        end else if (br_taken) begin
            w_sel = NPC_BR;
        end
    end

    always_comb begin
        w_next_pc = w_pc + 32'd4;
        unique case (w_sel)
            NPC_EXC:  w_next_pc = HANDLER;
            NPC_ERET: w_next_pc = epc;
            NPC_HOLD: w_next_pc = w_pc;
            NPC_BR:   w_next_pc = br_target;
            NPC_SEQ:  w_next_pc = w_pc + 32'd4;
            default:  w_next_pc = w_pc + 32'd4;
        endcase
    end

    assign w_load = (w_sel != NPC_HOLD);

    fetch_unit_pc_reg #(
        .RESET_VAL (PC_RESET)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (reset),
        .i_load (w_load),
        .i_d    (w_next_pc),
        .o_q    (w_pc)
    );

    assign w_bad = fetch_addr_bad(w_pc, IM_BASE, IM_TOP);

    // A bad PC still needs a legal memory index, so point it at the base.
    assign im_addr   = w_bad ? IM_BASE : w_pc;
    assign F_PC      = w_pc;
    assign F_Instr   = w_bad ? 32'd0 : im_instr;
    assign F_exc     = w_bad;
    assign F_ExcCode = w_bad ? EXC_ADEL : 5'd0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_exc;
    logic [4:0]  F_ExcCode;

    int unsigned n_total;
    int unsigned n_bad;
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .exc_req   (exc_req),
        .eret      (eret),
        .epc       (epc),
        .im_addr   (im_addr),
        .im_instr  (im_instr),
        .F_PC      (F_PC),
        .F_Instr   (F_Instr),
        .F_exc     (F_exc),
        .F_ExcCode (F_ExcCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory stand-in: every address maps to a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb im_instr = mem_word(im_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_is_bad(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
    endfunction

    task automatic check_all(input string tag);
        bit b;
        b = addr_is_bad(exp_pc);
        chk({tag, ".F_PC"},      F_PC,                 exp_pc);
        chk({tag, ".im_addr"},   im_addr,              b ? 32'h3000 : exp_pc);
        chk({tag, ".F_Instr"},   F_Instr,              b ? 32'd0 : mem_word(exp_pc));
        chk({tag, ".F_exc"},     {31'd0, F_exc},       {31'd0, b});
        chk({tag, ".F_ExcCode"}, {27'd0, F_ExcCode},   b ? 32'd4 : 32'd0);
    endtask

    function automatic logic [31:0] model_next();
        if (exc_req)   return 32'h4180;
        if (eret)      return epc;
        if (stall)     return exp_pc;
        if (br_taken)  return br_target;
        return exp_pc + 32'd4;
    endfunction

    task automatic tick(input string tag);
        logic [31:0] nxt;
        nxt = model_next();
        @(posedge clk);
        #1;
        exp_pc = nxt;
        check_all(tag);
    endtask

    // Reset pulse placed entirely between two rising edges.
    task automatic reset_pulse(input string tag);
        #3;
        reset = 1'b1;
        #1;
        exp_pc = 32'h3000;
        check_all(tag);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; br_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return 32'h3000 + 4 * $urandom_range(0, 32'h0FFF);
            3:       return 32'h6FFC;
            4:       return 32'h3000 + 4 * $urandom_range(0, 32'h0FFF) + $urandom_range(1, 3);
            5:       return 32'h7000;
            6:       return 32'h2FFC;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        br_target = 32'd0;
        epc       = 32'd0;
        idle_inputs();
        exp_pc  = 32'h3000;
        #12;
        reset = 1'b0;
        #1;
        check_all("reset");

        tick("seq1");
        tick("seq2");
        tick("seq3");

        reset_pulse("reset_mid");

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
        tick("stall_br1");
        tick("stall_br2");
        stall = 1'b0;
        tick("br_after_stall");
        chk("br_after_stall.target", F_PC, 32'h3100);
        idle_inputs();

        br_taken = 1'b1; br_target = 32'h3010;
        tick("goto_3010");
        br_taken = 1'b0;
        exc_req = 1'b1; stall = 1'b1;
        tick("exc_over_stall");
        chk("exc_over_stall.handler", F_PC, 32'h4180);
        idle_inputs();

        br_taken = 1'b1; br_target = 32'h3010;
        tick("goto_3010b");
        br_taken = 1'b0;
        exc_req = 1'b1; stall = 1'b1; eret = 1'b1; epc = 32'h3024;
        tick("exc_over_eret");
        idle_inputs();

        eret = 1'b1; epc = 32'h3024; stall = 1'b1;
        tick("eret_over_stall");
        chk("eret_over_stall.epc", F_PC, 32'h3024);
        idle_inputs();

        br_taken = 1'b1; br_target = 32'h3002;
        tick("misaligned");
        chk("misaligned.exc", {31'd0, F_exc}, 32'd1);
        br_target = 32'h7000;
        tick("above_top");
        chk("above_top.im_addr", im_addr, 32'h3000);
        br_target = 32'h6FFC;
        tick("at_top");
        br_target = 32'h2FFC;
        tick("below_base");
        br_target = 32'hFFFF_FFFC;
        tick("near_wrap");
        br_taken = 1'b0;
        tick("wrapped");
        chk("wrapped.pc", F_PC, 32'h0000_0000);

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h5000;
        reset_pulse("reset_in_stall");
        idle_inputs();
        tick("after_reset");

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            exc_req   = (r < 5);
            eret      = (r >= 5 && r < 13) || (r == 2);
            stall     = ($urandom_range(0, 3) == 0);
            br_taken  = ($urandom_range(0, 2) == 0);
            br_target = pick_addr();
            epc       = pick_addr();
            tick("rand");
            if ($urandom_range(0, 49) == 0) reset_pulse("rand_reset");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the P7 MIPS pipeline. Owns the program counter, selects the next PC from sequential, branch/jump, exception-entry and `eret` sources, and presents a word address to the instruction memory, which is combinational and spans `0x00003000`–`0x00006FFC`. It checks the fetch address and flags AdEL for misaligned or out-of-range PCs. Its F-stage outputs feed the F/D pipeline register.

## Interface
Parameters:
- `PC_RESET` = `32'h0000_3000` — PC after reset.
- `HANDLER` = `32'h0000_4180` — exception/interrupt entry address.
- `IM_BASE` = `32'h0000_3000` — lowest legal fetch address.
- `IM_TOP` = `32'h0000_6FFC` — highest legal fetch address.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high.
- `stall` in 1 — hazard unit holds the F stage.
- `br_taken` in 1 — branch/jump resolved in D, redirect.
- `br_target` in 32 — redirect target.
- `exc_req` in 1 — CP0 requests exception/interrupt entry.
- `eret` in 1 — `eret` in M; return to `epc`.
- `epc` in 32 — CP0 EPC.
- `im_addr` out 32 — address to instruction memory.
- `im_instr` in 32 — word returned combinationally by instruction memory.
- `F_PC` out 32 — PC of the instruction in F.
- `F_Instr` out 32 — instruction in F; `0` (nop) when `F_exc`.
- `F_exc` out 1 — fetch address exception in F.
- `F_ExcCode` out 5 — `5'd4` (AdEL) when `F_exc`, else `0`.

## Operation
- The PC register is the only state. `F_PC` is the PC register.
- Next-PC priority, highest first:
  1. `exc_req` → `HANDLER`
  2. `eret` → `epc`
  3. `stall` → hold
  4. `br_taken` → `br_target`
  5. otherwise → `PC+4`
- `exc_req` and `eret` both override `stall`.
- `exc_req` wins over a simultaneous `eret`.
- While `stall` is asserted, `br_taken` is ignored. The hazard unit keeps the branch in D and re-presents it after the stall drops.
- Address check, combinational on the PC:
  - bad = `PC[1:0]!=0` or `PC<IM_BASE` or `PC>IM_TOP`.
  - Comparisons are unsigned, 32-bit.
- When the address is bad:
  - `F_exc=1`, `F_ExcCode=4`, `F_Instr=0`.
  - `im_addr` is forced to `IM_BASE` so the memory index stays in range.
- When the address is good: `im_addr=PC`, `F_Instr=im_instr`, `F_exc=0`, `F_ExcCode=0`.
- `PC+4` is 32-bit and wraps silently. Wrap-around is caught by the range check.
- `epc` and `br_target` are used unmodified. Alignment faults surface through AdEL on the following fetch.

## Timing
- Reset, asynchronous: the PC goes to `PC_RESET` immediately.
  - `F_PC=0x3000`, `im_addr=0x3000`, `F_exc=0`, `F_ExcCode=0`.
  - `F_Instr` = memory word at `0x3000`.
- Redirect latency is one cycle: a source sampled at edge N sets `F_PC` after edge N.
- All outputs are combinational from the PC register and `im_instr`. There are no registered outputs and no inputs on a combinational path to the PC.
- If `reset` deasserts mid-cycle, the first update happens on the next rising edge.
- If `reset` asserts during a stall or a redirect, reset wins.

## Structure
- Shared package/header: `PC_RESET`, `HANDLER`, `IM_BASE`, `IM_TOP`, and ExcCode constant `EXC_ADEL=5'd4`. These are shared with CP0 and the ExcCode pipeline.
- One sub-module is natural: `pc_reg`, a 32-bit async-reset register with load-enable.
- Next-PC mux and address check stay in `fetch_unit`.

## Test plan
- Reset pulse mid-run: `F_PC` becomes `0x3000` without a clock edge; `F_exc=0`.
- Free run, no control inputs, 3 edges: `F_PC` = `0x3004`, `0x3008`, `0x300C`, with `F_Instr` matching memory.
- `stall=1` for 2 cycles together with `br_taken=1`, `br_target=0x3100`: `F_PC` holds. After the stall drops and `br_taken` stays 1 for one edge, `F_PC=0x3100`.
- `exc_req=1` and `stall=1` together at PC `0x3010`: next `F_PC=0x4180`. The same result occurs when `eret=1` is also asserted.
- `eret=1`, `epc=0x3024`, with `stall=1`: next `F_PC=0x3024`.
- `br_target=0x3002`: next cycle `F_exc=1`, `F_ExcCode=4`, `F_Instr=0`, `im_addr=0x3000`.
- `br_target=0x7000`: same AdEL response as the misaligned case.
